instr_fetch: RTL and testbench

// - Fetch stage feeding the CPU execute stage: holds a small program of {opcode, operand1, operand2} words.
// - On start, walks the program from address 0 and presents each instruction over a valid/ready handshake.
// - Program is loaded through a write port while idle; done pulses after the last instruction is accepted.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a small program store walked from address 0 on start,
// issuing each {opcode, operand1, operand2} word to the execute stage over valid/ready.
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [17:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          abort,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [1:0]    out_opcode,
    output logic [7:0]    out_operand1,
    output logic [7:0]    out_operand2,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [1:0]    dbg_state
);

    // Handshake: a word transfers on any rising edge where out_valid & out_ready are both
    // high; once raised, out_valid and out_* hold steady until that transfer (or an abort).

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          valid_q, valid_d;
    logic [17:0]   word_q, word_d;
    logic [17:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW:0]   len_clamped;
    logic          last_word;

    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_word   = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
    assign mem_we      = (state_q == S_IDLE) && prog_we;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        valid_d = valid_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_clamped;
                    pc_d    = '0;
                    state_d = (len_clamped != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end else begin
                    word_d  = mem[pc_q];
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // abort wins over a handshake in the same cycle
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    pc_d    = '0;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    // Program store is deliberately left out of reset so a program survives a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign out_valid    = valid_q;
    assign out_opcode   = word_q[17:16];
    assign out_operand1 = word_q[15:8];
    assign out_operand2 = word_q[7:0];
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign pc           = pc_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: program load, issue, stalls, zero/over length,
// abort, writes while busy, and asynchronous reset mid-run.
module tb_instr_fetch;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [17:0] W0 = 18'h00304;  // {00, 03, 04}
    localparam logic [17:0] W1 = 18'h10A02;  // {01, 0A, 02}

    logic          clk;
    logic          reset_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [17:0]   prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic          out_ready;
    logic          out_valid;
    logic [1:0]    out_opcode;
    logic [7:0]    out_operand1;
    logic [7:0]    out_operand2;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [1:0]    dbg_state;

    int vectors;
    int miscompares;
    logic [17:0] exp_q[$];

    instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .start        (start),
        .abort        (abort),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_opcode   (out_opcode),
        .out_operand1 (out_operand1),
        .out_operand2 (out_operand2),
        .busy         (busy),
        .done         (done),
        .pc           (pc),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic prog_write(input logic [AW-1:0] addr, input logic [17:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic start_run(input logic [AW:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic drain(input string name);
        int seen;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            tick();
            if (done) seen = 1;
        end
        tick();
        vectors++;
        if (seen != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: done_seen=%0d busy=%b, required done_seen=1 busy=0", name, seen, busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, busy, done, pc, dbg_state} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b pc=%0d st=%0d, required all 0",
                     out_valid, busy, done, pc, dbg_state);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({out_valid, busy, done, pc} !== '0) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b busy=%b done=%b pc=%0d, required all 0",
                     out_valid, busy, done, pc);
        end
    endtask

    task automatic test_basic();
        prog_write(4'd0, W0);
        prog_write(4'd1, W1);
        out_ready = 1'b1;
        start_run(5'd2);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_fetch: busy=%b valid=%b, required busy=1 valid=0", busy, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || {out_opcode, out_operand1, out_operand2} !== W0 || pc !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_word0: valid=%b word=%h pc=%0d, required valid=1 word=%h pc=0",
                     out_valid, {out_opcode, out_operand1, out_operand2}, pc, W0);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_gap: valid=%b pc=%0d, required valid=0 pc=1", out_valid, pc);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || {out_opcode, out_operand1, out_operand2} !== W1 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL basic_word1: valid=%b word=%h pc=%0d, required valid=1 word=%h pc=1",
                     out_valid, {out_opcode, out_operand1, out_operand2}, pc, W1);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done: done=%b valid=%b busy=%b, required done=1 valid=0 busy=1",
                     done, out_valid, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || pc !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_idle: done=%b busy=%b pc=%0d, required done=0 busy=0 pc=0", done, busy, pc);
        end
    endtask

    task automatic test_stall();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        start_run(5'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || {out_opcode, out_operand1, out_operand2} !== W0 || pc !== 4'd0)
                bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL stall_hold: %0d of 5 cycles lost valid/word/pc, required 0 (word=%h pc=%0d)",
                     bad, {out_opcode, out_operand1, out_operand2}, pc);
        end
        // start while busy must not restart the run
        prog_len = 5'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || pc !== 4'd0 || dbg_state !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_restart: valid=%b pc=%0d st=%0d, required valid=1 pc=0 st=2",
                     out_valid, pc, dbg_state);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL stall_release: valid=%b pc=%0d, required valid=0 pc=1", out_valid, pc);
        end
        drain("stall");
    endtask

    task automatic test_zero_len();
        start_run(5'd0);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: busy=%b done=%b valid=%b, required busy=1 done=1 valid=0",
                     busy, done, out_valid);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_idle: busy=%b done=%b valid=%b, required all 0", busy, done, out_valid);
        end
    endtask

    task automatic test_overlen();
        int hs;
        int seen_done;
        logic [17:0] w;
        logic [17:0] exp_w;
        hs = 0;
        seen_done = 0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w = {2'(i), 8'(i + 8'h11), 8'(8'hF0 ^ i)};
            prog_write(AW'(i), w);
            exp_q.push_back(w);
        end
        out_ready = 1'b1;
        start_run(5'd20);
        for (int c = 0; c < 100 && seen_done == 0; c++) begin
            tick();
            if (out_valid === 1'b1) begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h0;
                vectors++;
                if ({out_opcode, out_operand1, out_operand2} !== exp_w || pc !== AW'(hs)) begin
                    miscompares++;
                    $display("FAIL overlen_word%0d: word=%h pc=%0d, required word=%h pc=%0d",
                             hs, {out_opcode, out_operand1, out_operand2}, pc, exp_w, hs);
                end
                hs++;
            end
            if (done === 1'b1) seen_done = 1;
        end
        vectors++;
        if (hs != DEPTH || seen_done != 1) begin
            miscompares++;
            $display("FAIL overlen_count: handshakes=%0d done_seen=%0d, required handshakes=16 done_seen=1",
                     hs, seen_done);
        end
        tick();
    endtask

    task automatic test_abort();
        prog_write(4'd0, W0);
        prog_write(4'd1, W1);
        out_ready = 1'b1;
        start_run(5'd2);
        tick(); tick(); tick();
        vectors++;
        if (out_valid !== 1'b1 || pc !== 4'd1) begin
            miscompares++;
            $display("FAIL abort_setup: valid=%b pc=%0d, required valid=1 pc=1", out_valid, pc);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b pc=%0d st=%0d, required 0 0 0 0 0",
                     out_valid, busy, done, pc, dbg_state);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_nodone: done=%b, required 0", done);
        end
        start_run(5'd2);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || pc !== 4'd0 || {out_opcode, out_operand1, out_operand2} !== W0) begin
            miscompares++;
            $display("FAIL abort_restart: valid=%b pc=%0d word=%h, required valid=1 pc=0 word=%h",
                     out_valid, pc, {out_opcode, out_operand1, out_operand2}, W0);
        end
        drain("abort");
    endtask

    task automatic test_write_busy();
        out_ready = 1'b0;
        start_run(5'd2);
        tick();
        prog_write(4'd0, 18'h3FFFF);
        drain("wbusy");
        out_ready = 1'b0;
        start_run(5'd2);
        tick();
        vectors++;
        if ({out_opcode, out_operand1, out_operand2} !== W0) begin
            miscompares++;
            $display("FAIL write_busy: mem0=%h, required %h", {out_opcode, out_operand1, out_operand2}, W0);
        end
        // asynchronous reset in the middle of this stalled run
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || pc !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b busy=%b pc=%0d, required 0 0 0", out_valid, busy, pc);
        end
        tick();
        reset_n = 1'b1;
        tick();
        start_run(5'd1);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || {out_opcode, out_operand1, out_operand2} !== W0) begin
            miscompares++;
            $display("FAIL mem_kept: valid=%b word=%h, required valid=1 word=%h",
                     out_valid, {out_opcode, out_operand1, out_operand2}, W0);
        end
        drain("kept");
    endtask

    task automatic test_write_and_start();
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 18'h20505;
        prog_len  = 5'd1;
        start     = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || {out_opcode, out_operand1, out_operand2} !== 18'h20505) begin
            miscompares++;
            $display("FAIL write_start: valid=%b word=%h, required valid=1 word=20505",
                     out_valid, {out_opcode, out_operand1, out_operand2});
        end
        drain("wstart");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_len    = '0;
        start       = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_overlen();
        test_abort();
        test_write_busy();
        test_write_and_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
